// File: rtl/i2c_target.sv
// I2C target responder: filtered SCL/SDA front end, START/STOP detection,
// 7-bit address match and a byte-stream write/read interface.
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       rd_nack,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
        S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
    } state_t;

    localparam logic [3:0] FLEN = 4'(FILTER_LEN);

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic [3:0] scl_cnt_q, sda_cnt_q;
    logic scl_f_q, sda_f_q, scl_p_q, sda_p_q;
    logic scl_s, sda_s;
    logic ev_start, ev_stop, ev_rise, ev_fall;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wvalid_q, wvalid_d;
    logic       rreq_q, rreq_d;
    logic       rnack_q, rnack_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       rw_q, rw_d;
    logic       phase_q, phase_d;
    logic       ack_q, ack_d;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Synchronise pins; idle-high reset avoids a false STOP after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        end
    end

    // Glitch filter: level follows only after FILTER_LEN differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_p_q   <= 1'b1;
            sda_p_q   <= 1'b1;
        end else begin
            scl_p_q <= scl_f_q;
            sda_p_q <= sda_f_q;
            if (scl_s == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q + 4'd1 == FLEN) begin
                scl_f_q   <= scl_s;
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 4'd1;
            end
            if (sda_s == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q + 4'd1 == FLEN) begin
                sda_f_q   <= sda_s;
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 4'd1;
            end
        end
    end

    assign ev_start = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
    assign ev_stop  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
    assign ev_rise  = scl_f_q & ~scl_p_q;
    assign ev_fall  = ~scl_f_q & scl_p_q;

    // Protocol state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            rreq_q   <= 1'b0;
            rnack_q  <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            rw_q     <= 1'b0;
            phase_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
            rreq_q   <= rreq_d;
            rnack_q  <= rnack_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            rw_q     <= rw_d;
            phase_q  <= phase_d;
            ack_q    <= ack_d;
        end
    end

    // Next-state: bus events first, then per-state bit handling.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        wdata_d  = wdata_q;
        rw_d     = rw_q;
        phase_d  = phase_q;
        ack_d    = ack_q;
        wvalid_d = 1'b0;
        rreq_d   = 1'b0;
        rnack_d  = 1'b0;
        start_d  = 1'b0;
        stop_d   = 1'b0;
        if (rreq_q) shift_d = rd_data;
        if (ev_start) begin
            start_d  = 1'b1;
            oe_d     = 1'b0;
            bitcnt_d = 3'd7;
            busy_d   = 1'b0;
            state_d  = S_ADDR;
        end else if (ev_stop) begin
            stop_d   = 1'b1;
            oe_d     = 1'b0;
            bitcnt_d = 3'd7;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_ADDR: if (ev_rise) begin
                    shift_d  = {shift_q[6:0], sda_f_q};
                    bitcnt_d = bitcnt_q - 3'd1;
                    if (bitcnt_q == 3'd0) begin
                        phase_d = 1'b0;
                        rw_d    = sda_f_q;
                        if (shift_q[6:0] == ADDR) begin
                            busy_d  = 1'b1;
                            state_d = S_ADDR_ACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (ev_fall && !phase_q) begin
                        oe_d    = 1'b1;
                        phase_d = 1'b1;
                    end else if (ev_rise && phase_q && rw_q) begin
                        rreq_d = 1'b1;
                    end else if (ev_fall && phase_q) begin
                        bitcnt_d = 3'd7;
                        phase_d  = 1'b0;
                        if (rw_q) begin
                            oe_d    = ~shift_q[7];
                            state_d = S_RD_BYTE;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = S_WR_BYTE;
                        end
                    end
                end
                S_WR_BYTE: if (ev_rise) begin
                    shift_d  = {shift_q[6:0], sda_f_q};
                    bitcnt_d = bitcnt_q - 3'd1;
                    if (bitcnt_q == 3'd0) begin
                        phase_d = 1'b0;
                        ack_d   = wr_ready;
                        if (wr_ready) begin
                            wdata_d  = {shift_q[6:0], sda_f_q};
                            wvalid_d = 1'b1;
                        end
                        state_d = S_WR_ACK;
                    end
                end
                S_WR_ACK: if (ev_fall) begin
                    if (!phase_q) begin
                        oe_d    = ack_q;
                        phase_d = 1'b1;
                    end else begin
                        oe_d     = 1'b0;
                        phase_d  = 1'b0;
                        bitcnt_d = 3'd7;
                        state_d  = S_WR_BYTE;
                    end
                end
                S_RD_BYTE: if (ev_fall) begin
                    if (phase_q) begin
                        oe_d     = ~shift_q[7];
                        bitcnt_d = 3'd7;
                        phase_d  = 1'b0;
                    end else if (bitcnt_q == 3'd0) begin
                        oe_d    = 1'b0;
                        state_d = S_RD_ACK;
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                        oe_d     = ~shift_q[bitcnt_q - 3'd1];
                    end
                end
                S_RD_ACK: if (ev_rise) begin
                    if (!sda_f_q) begin
                        rreq_d  = 1'b1;
                        phase_d = 1'b1;
                        state_d = S_RD_BYTE;
                    end else begin
                        rnack_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IGNORE;
                    end
                end
                S_IGNORE: oe_d = 1'b0;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign sda_oe    = oe_q;
    assign wr_data   = wdata_q;
    assign wr_valid  = wvalid_q;
    assign rd_req    = rreq_q;
    assign rd_nack   = rnack_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged bus controller with open-drain
// SDA model, event counters and hand-computed expectations.
module tb_i2c_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       wr_ready = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic       sda_line;
    logic       sda_oe, wr_valid, rd_req, rd_nack;
    logic       start_det, stop_det, busy;
    logic [7:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wv = 0, n_rr = 0, n_rn = 0, n_st = 0, n_sp = 0, n_oe = 0;
    logic [7:0] wr_log[$];

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_nack   (rd_nack),
        .start_det (start_det),
        .stop_det  (stop_det),
        .busy      (busy)
    );

    // Count output pulses and log accepted write bytes.
    always @(posedge clk) begin
        if (wr_valid) begin
            n_wv++;
            wr_log.push_back(wr_data);
        end
        if (rd_req) n_rr++;
        if (rd_nack) n_rn++;
        if (start_det) n_st++;
        if (stop_det) n_sp++;
        if (sda_oe) n_oe++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic waitq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; waitq();
        scl_m = 1'b1; waitq();
        sda_m = 1'b0; waitq();
        scl_m = 1'b0; waitq();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; waitq();
        scl_m = 1'b1; waitq();
        sda_m = 1'b1; waitq();
        waitq();
    endtask

    task automatic bus_bit(input logic b, input bit glitch, output logic r);
        sda_m = b;
        if (glitch) begin
            repeat (2) @(negedge clk);
            scl_m = 1'b1;
            @(negedge clk);
            scl_m = 1'b0;
            repeat (Q - 3) @(negedge clk);
        end else begin
            waitq();
        end
        scl_m = 1'b1;
        repeat (2 * Q) @(negedge clk);
        r = sda_line;
        scl_m = 1'b0;
        waitq();
    endtask

    task automatic bus_byte(input logic [7:0] tx, input int gl,
                            output logic [7:0] rx);
        logic t;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(tx[i], (i == gl), t);
            rx[i] = t;
        end
    endtask

    logic [7:0] rx;
    logic       ak;
    int b_wv, b_rr, b_rn, b_st, b_sp, b_oe, b_log;

    initial begin
        repeat (4) @(negedge clk);
        check("reset_outputs",
              {sda_oe, wr_valid, rd_req, rd_nack, start_det, stop_det,
               busy, wr_data}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Write 0x42: A5, 3C
        b_wv = n_wv; b_sp = n_sp; b_log = wr_log.size();
        bus_start();
        bus_byte(8'h84, -1, rx); bus_bit(1'b1, 0, ak);
        check("wr_addr_ack", ak, 0);
        check("wr_busy", busy, 1);
        bus_byte(8'hA5, -1, rx); bus_bit(1'b1, 0, ak);
        check("wr_d0_ack", ak, 0);
        bus_byte(8'h3C, -1, rx); bus_bit(1'b1, 0, ak);
        check("wr_d1_ack", ak, 0);
        bus_stop();
        check("wr_valid_cnt", n_wv - b_wv, 2);
        check("wr_data0", wr_log[b_log], 8'hA5);
        check("wr_data1", wr_log[b_log + 1], 8'h3C);
        check("wr_stop_cnt", n_sp - b_sp, 1);
        check("wr_busy_end", busy, 0);

        // Wrong address 0x43
        b_wv = n_wv; b_oe = n_oe;
        bus_start();
        bus_byte(8'h86, -1, rx); bus_bit(1'b1, 0, ak);
        check("bad_addr_nack", ak, 1);
        check("bad_busy", busy, 0);
        bus_byte(8'h11, -1, rx); bus_bit(1'b1, 0, ak);
        check("bad_data_nack", ak, 1);
        bus_stop();
        check("bad_oe_cycles", n_oe - b_oe, 0);
        check("bad_wv", n_wv - b_wv, 0);

        // Read 0x42: 5A (ACK), F0 (NACK)
        b_rr = n_rr; b_rn = n_rn;
        rd_data = 8'h5A;
        bus_start();
        bus_byte(8'h85, -1, rx); bus_bit(1'b1, 0, ak);
        check("rd_addr_ack", ak, 0);
        rd_data = 8'hF0;
        bus_byte(8'hFF, -1, rx); bus_bit(1'b0, 0, ak);
        check("rd_byte0", rx, 8'h5A);
        bus_byte(8'hFF, -1, rx); bus_bit(1'b1, 0, ak);
        check("rd_byte1", rx, 8'hF0);
        check("rd_oe_after", sda_oe, 0);
        check("rd_req_cnt", n_rr - b_rr, 2);
        check("rd_nack_cnt", n_rn - b_rn, 1);
        check("rd_busy_end", busy, 0);
        bus_stop();

        // wr_ready low: NACK, byte dropped, next byte taken
        b_wv = n_wv; b_log = wr_log.size();
        bus_start();
        bus_byte(8'h84, -1, rx); bus_bit(1'b1, 0, ak);
        wr_ready = 1'b0;
        bus_byte(8'h77, -1, rx); bus_bit(1'b1, 0, ak);
        check("nrdy_nack", ak, 1);
        wr_ready = 1'b1;
        bus_byte(8'h99, -1, rx); bus_bit(1'b1, 0, ak);
        check("nrdy_next_ack", ak, 0);
        bus_stop();
        check("nrdy_wv", n_wv - b_wv, 1);
        check("nrdy_data", wr_log[b_log], 8'h99);

        // Write then repeated START into read
        b_st = n_st; b_sp = n_sp; b_log = wr_log.size();
        rd_data = 8'hC3;
        bus_start();
        bus_byte(8'h84, -1, rx); bus_bit(1'b1, 0, ak);
        bus_byte(8'h12, -1, rx); bus_bit(1'b1, 0, ak);
        check("rs_wr_ack", ak, 0);
        bus_start();
        bus_byte(8'h85, -1, rx); bus_bit(1'b1, 0, ak);
        check("rs_rd_addr_ack", ak, 0);
        bus_byte(8'hFF, -1, rx); bus_bit(1'b1, 0, ak);
        check("rs_rd_byte", rx, 8'hC3);
        check("rs_start_cnt", n_st - b_st, 2);
        check("rs_no_stop", n_sp - b_sp, 0);
        check("rs_wr_data", wr_log[b_log], 8'h12);
        bus_stop();

        // SCL glitch mid-byte
        b_log = wr_log.size();
        bus_start();
        bus_byte(8'h84, -1, rx); bus_bit(1'b1, 0, ak);
        bus_byte(8'h5E, 3, rx); bus_bit(1'b1, 0, ak);
        check("gl_ack", ak, 0);
        check("gl_data", wr_log[b_log], 8'h5E);
        check("gl_log_len", wr_log.size() - b_log, 1);
        bus_stop();

        // Reset mid-read while target drives SDA low
        rd_data = 8'h00;
        bus_start();
        bus_byte(8'h85, -1, rx); bus_bit(1'b1, 0, ak);
        for (int i = 0; i < 3; i++) bus_bit(1'b1, 0, ak);
        check("mid_rd_oe", sda_oe, 1);
        rst = 1'b1;
        #1;
        check("rst_async_out",
              {sda_oe, wr_valid, rd_req, rd_nack, start_det, stop_det,
               busy, wr_data}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        bus_stop();
        b_log = wr_log.size();
        bus_start();
        bus_byte(8'h84, -1, rx); bus_bit(1'b1, 0, ak);
        check("post_rst_addr_ack", ak, 0);
        bus_byte(8'h6B, -1, rx); bus_bit(1'b1, 0, ak);
        bus_stop();
        check("post_rst_data", wr_log[b_log], 8'h6B);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
